inst_queue: RTL
===============

Name: inst_queue

Overview:
- Parametrised instruction register successor: a DEPTH-entry instruction queue between the fetch stage and the decode stage.
- Each entry holds an instruction word together with its PC.
- Valid/ready handshake on both sides lets fetch run ahead of a stalled decode.
- Synchronous flush discards all queued entries on branch/jump redirect.

Parameters:
- BITS, 32, instruction word width.
- PC_BITS, 32, program counter width.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_BITS, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept an entry.
- in_data  input  BITS  instruction word.
- in_pc  input  PC_BITS  PC of in_data.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head.
- out_data  output  BITS  head instruction; NOP when empty.
- out_pc  output  PC_BITS  head PC; 0 when empty.
- count  output  CNT_BITS  current occupancy, 0..DEPTH.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - write pointer, read pointer and count cleared to 0.
  - out_valid=0, in_ready=1, count=0, out_data=NOP (32'h00000013), out_pc=0.
  - Storage array contents are not reset.
  - Reset asserted mid-operation drops every entry immediately, with no partial pop.
- Push = in_valid & in_ready:
  - writes {in_data, in_pc} at the write pointer.
  - write pointer advances modulo DEPTH; wraps DEPTH-1 -> 0.
- Pop = out_valid & out_ready:
  - read pointer advances modulo DEPTH.
- in_ready = (count != DEPTH).
  - Depends only on state, so there is no combinational path from out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data/out_pc are driven from the head entry when valid, else NOP/0.
- Latency:
  - An entry pushed in cycle N is visible at the output in cycle N+1.
  - There is no same-cycle bypass when the queue is empty.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Flush (sync, highest priority after reset):
  - At the edge, pointers and count go to 0.
  - Any push or pop offered in that cycle is ignored; the pushed word is not stored.
  - Next cycle: out_valid=0, in_ready=1.
- Boundary cases:
  - pop while empty is impossible, because out_valid=0.
  - push while full is impossible, because in_ready=0.
  - count never exceeds DEPTH and never underflows.
- Ordering: strictly FIFO; PC stays paired with its instruction.
- out_data/out_pc only change on the cycle after a pop, push-into-empty, flush or reset.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h00000013 (addi x0,x0,0).
  - Default BITS/PC_BITS constants.
  - queue_entry_t struct {data, pc}.
- One natural sub-module: wrap_ptr.
  - Parametrised modulo-DEPTH pointer with inc and clr inputs and async active-low reset.
  - Instantiated twice, once for the read pointer and once for the write pointer.
- Count logic and output muxing stay in inst_queue.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, count=0, out_data=32'h00000013, out_pc=0. Release, then push 32'h00500093 @pc 0x0 -> the next cycle shows out_valid=1, out_data=32'h00500093, out_pc=0x0.
- Fill and wrap: with out_ready=0, push 4 words A0..A3 (pc 0x0,0x4,0x8,0xC) -> count=4, in_ready=0, and a fifth push is not accepted. Pop 2, push B0, B1 -> pops return A0..A3 then B0, B1 in order; write pointer has wrapped.
- Simultaneous push/pop at count=2 for 5 cycles -> count stays 2, and the output sequence matches the input order.
- Full plus pop: at count=4 with in_valid=1 and out_ready=1 -> the pop happens, the push is refused, count=3, in_ready=1 next cycle.
- Flush: at count=3 with in_valid=1 and 32'h00100113 offered -> next cycle count=0, out_valid=0, out_data=NOP. That word never appears at the output.
- Async reset mid-stream: drop rst_n between clock edges at count=2 -> outputs go to reset values immediately without waiting for a clock edge. After release, the first pushed word is the first popped.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   NOP_INSTR     : canonical no-op (addi x0,x0,0) shown when nothing is queued
//   BITS_DEF      : default instruction word width
//   PC_BITS_DEF   : default program counter width
//   queue_entry_t : instruction word paired with its PC at the default widths
package riscv_pkg;

    localparam int BITS_DEF    = 32;
    localparam int PC_BITS_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [BITS_DEF-1:0]    data;
        logic [PC_BITS_DEF-1:0] pc;
    } queue_entry_t;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, pointer to 0
//   clr   : synchronous clear to 0, wins over inc
//   inc   : advance by one, wrapping DEPTH-1 -> 0
//   ptr   : current pointer value
module wrap_ptr #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [PTR_BITS-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            // Explicit wrap keeps the pointer correct even if DEPTH were not a power of two.
            if (ptr == PTR_BITS'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// DEPTH entries of {instruction, PC} with valid/ready handshakes on both sides,
// so fetch can run ahead while decode is stalled.
//   clk, rst_n          : clock and asynchronous active-low reset
//   flush               : synchronous discard of every entry (branch/jump redirect)
//   in_valid/in_ready   : fetch-side handshake; in_data/in_pc the offered entry
//   out_valid/out_ready : decode-side handshake; out_data/out_pc the head entry
//                         (NOP / 0 when empty)
//   count               : occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2.
module inst_queue
    import riscv_pkg::*;
#(
    parameter  int BITS     = BITS_DEF,
    parameter  int PC_BITS  = PC_BITS_DEF,
    parameter  int DEPTH    = 4,
    localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    input  logic [PC_BITS-1:0]  in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_data,
    output logic [PC_BITS-1:0]  out_pc,
    output logic [CNT_BITS-1:0] count
);

    localparam int PTR_BITS = $clog2(DEPTH);

    typedef struct packed {
        logic [BITS-1:0]    data;
        logic [PC_BITS-1:0] pc;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              head;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                push;
    logic                pop;

    // Both readiness flags come from the registered count only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count != CNT_BITS'(DEPTH));
    assign out_valid = (count != '0);

    // Flush cancels whatever handshake happens in the same cycle.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    wrap_ptr #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    // Storage is data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: in_data, pc: in_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_BITS'(1);
        end else if (pop && !push) begin
            count <= count - CNT_BITS'(1);
        end
    end

    // No bypass: a freshly pushed word is seen only once count has moved off 0.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head.data : BITS'(NOP_INSTR);
    assign out_pc   = out_valid ? head.pc   : '0;

endmodule
